// File: rtl/i2c_nunchuck_target.sv
// Wii Nunchuk I2C target at DEVICE_ADDR: init handshake, register pointer, six-byte report served from a shadow copy.
// SCL/SDA are 2-FF synchronised; SDA updates <=3 clocks after SCL fall; never stretches SCL.
module i2c_nunchuck_target #(
    parameter logic [6:0] DEVICE_ADDR = 7'h52,
    parameter int         NUM_DATA    = 6
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       SCLpin,
    inout  wire        SDApin,
    input  logic [7:0] stick_x,
    input  logic [7:0] stick_y,
    input  logic [9:0] accel_x,
    input  logic [9:0] accel_y,
    input  logic [9:0] accel_z,
    input  logic       z,
    input  logic       c,
    output logic       ready,
    output logic       busy,
    output logic [7:0] reg_ptr,
    output logic       xfer_done
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK
    } state_t;

    localparam logic [7:0] LAST_PTR = 8'(NUM_DATA - 1);

    state_t     state;
    logic [3:0] bit_cnt;
    logic [6:0] shreg;
    logic       rw;
    logic       sda_oe;
    logic       addressed;
    logic       init1;
    logic [7:0] shadow [NUM_DATA];
    logic [7:0] report [6];

    logic scl_meta, scl_s, scl_d;
    logic sda_meta, sda_s, sda_d;

    assign SDApin = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            {scl_meta, scl_s, scl_d} <= 3'b111;
            {sda_meta, sda_s, sda_d} <= 3'b111;
        end else begin
            {scl_meta, scl_s, scl_d} <= {SCLpin, scl_meta, scl_s};
            {sda_meta, sda_s, sda_d} <= {SDApin, sda_meta, sda_s};
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = ~sda_s & sda_d & scl_s;
    assign stop_det  = sda_s & ~sda_d & scl_s;

    logic [7:0] rx_byte;
    assign rx_byte = {shreg, sda_s};

    always_comb begin
        report[0] = stick_x;
        report[1] = stick_y;
        report[2] = accel_x[9:2];
        report[3] = accel_y[9:2];
        report[4] = accel_z[9:2];
        report[5] = {accel_z[1:0], accel_y[1:0], accel_x[1:0], ~c, ~z};
    end

    // Out-of-range pointers and reads before the handshake return the bus idle value.
    logic [7:0] tx_byte;
    always_comb begin
        tx_byte = 8'hFF;
        for (int i = 0; i < NUM_DATA; i++)
            if (ready && reg_ptr == 8'(i)) tx_byte = shadow[i];
    end

    logic [7:0] ptr_next_rd;
    assign ptr_next_rd = (reg_ptr == LAST_PTR) ? 8'd0 : reg_ptr + 8'd1;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            shreg     <= 7'd0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            addressed <= 1'b0;
            init1     <= 1'b0;
            ready     <= 1'b0;
            reg_ptr   <= 8'd0;
            xfer_done <= 1'b0;
            for (int i = 0; i < NUM_DATA; i++) shadow[i] <= 8'd0;
        end else begin
            xfer_done <= 1'b0;
            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state     <= IDLE;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                addressed <= 1'b0;
                xfer_done <= addressed;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shreg   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (rx_byte[7:1] == DEVICE_ADDR) begin
                                state     <= ADDR_ACK;
                                rw        <= rx_byte[0];
                                busy      <= 1'b1;
                                addressed <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    // First SCL fall drives ACK, second releases it and starts the next byte.
                    ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                            if (state == ADDR_ACK && rw)
                                for (int i = 0; i < NUM_DATA; i++)
                                    shadow[i] <= (i < 6) ? report[i % 6] : 8'h00;
                        end else if (state == ADDR_ACK && rw) begin
                            state   <= RDATA;
                            sda_oe  <= ~tx_byte[7];
                            bit_cnt <= 4'd1;
                        end else begin
                            state   <= (state == ADDR_ACK) ? PTR : WDATA;
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                        end
                    end
                    PTR: if (scl_rise) begin
                        shreg   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            reg_ptr <= rx_byte;
                            state   <= PTR_ACK;
                        end
                    end
                    WDATA: if (scl_rise) begin
                        shreg   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (rx_byte == 8'h55 && reg_ptr == 8'hF0) init1 <= 1'b1;
                            if (rx_byte == 8'h00 && reg_ptr == 8'hFB && init1) ready <= 1'b1;
                            reg_ptr <= reg_ptr + 8'd1;
                            state   <= WDATA_ACK;
                        end
                    end
                    RDATA: if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe  <= 1'b0;
                            reg_ptr <= (reg_ptr <= LAST_PTR) ? ptr_next_rd : reg_ptr + 8'd1;
                            state   <= RDATA_MACK;
                        end else begin
                            sda_oe  <= ~tx_byte[3'd7 - bit_cnt[2:0]];
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    RDATA_MACK: begin
                        if (scl_rise && sda_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (scl_fall) begin
                            state   <= RDATA;
                            sda_oe  <= ~tx_byte[7];
                            bit_cnt <= 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_nunchuck_target.md
# i2c_nunchuck_target

I2C target (responder) that emulates a Wii Nunchuk at 7-bit address 0x52, the far end of the bus from the nunchuck driver. It honours the 0xF0←0x55 / 0xFB←0x00 init handshake, holds a register pointer, and returns the six-byte Nunchuk report packed from its input ports. It is used as a bench/board stand-in for the real peripheral, so the driver and translator can be exercised closed-loop on the FPGA and in simulation.

## Interface
- DEVICE_ADDR, 7'h52, 7-bit address this target ACKs
- NUM_DATA, 6, report length; data registers 0..NUM_DATA-1
- clock  input  1  system clock; all logic on posedge; must be ≥16× SCL frequency
- rst  input  1  reset, asynchronous, active-high
- SCLpin  input  1  bus clock from initiator; no clock stretching
- SDApin  inout  1  open-drain data; driven only to 0, else 1'bz
- stick_x, stick_y  input  8  joystick values
- accel_x, accel_y, accel_z  input  10  accelerometer values
- z, c  input  1  buttons, 1 = pressed
- ready  output  1  init handshake complete
- busy  output  1  high from addressed START until STOP/NACK-exit
- reg_ptr  output  8  current register pointer
- xfer_done  output  1  one-clock pulse at STOP ending a transaction addressed to us

## Operation
- SCLpin/SDApin pass 2-FF synchronizers; rise/fall detected from synchronized history. START = SDA fall while SCL high; STOP = SDA rise while SCL high.
- Bits sampled on SCL rise; SDA output updated on SCL fall (next clock after detection). MSB first.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK.
- START in any state (incl. repeated START) → ADDR, bit counter cleared, SDA released. STOP in any state → IDLE, SDA released.
- ADDR: 8 bits; if [7:1]==DEVICE_ADDR drive ACK (SDA=0) for the 9th bit, busy=1; else stay released, → IDLE. R/W=0 → PTR; R/W=1 → RDATA, and at this ACK the six report bytes are snapshotted into a shadow register (coherent frame).
- PTR: received byte loads reg_ptr; ACK; → WDATA.
- WDATA: each byte ACKed. Byte 0x55 with reg_ptr==0xF0 sets init1; byte 0x00 with reg_ptr==0xFB while init1 sets ready. Other writes ignored. reg_ptr increments after each data byte.
- RDATA: transmit shadow[reg_ptr] if reg_ptr<NUM_DATA and ready; else 0xFF. Release SDA for 9th bit; RDATA_MACK samples initiator: ACK (0) → next byte, NACK (1) → IDLE (await STOP/START).
- Report packing: byte0 stick_x; byte1 stick_y; byte2 accel_x[9:2]; byte3 accel_y[9:2]; byte4 accel_z[9:2]; byte5 {accel_z[1:0], accel_y[1:0], accel_x[1:0], ~c, ~z}.
- Pointer arithmetic: 8-bit; within data range wraps NUM_DATA-1 → 0 on read; outside range increments mod 256.
- ready cleared only by rst.

## Timing
- Reset values: SDApin released (z), ready=0, busy=0, reg_ptr=0, xfer_done=0, state IDLE, shadow=0, init1=0.
- SDA change ≤3 clocks after true SCL fall (2 sync + 1 register); held through SCL high.
- ACK asserted from SCL fall after bit 8 until SCL fall after bit 9, then released/next data bit.
- xfer_done pulses 1 clock, 3 clocks after the STOP SDA edge; busy drops same cycle.
- rst mid-transfer: SDA released immediately (async); target ignores bus until next START.
- START and STOP detection take priority over bit sampling in the same clock.

## Test plan
- Handshake: write 0x52 W, 0xF0, 0x55, STOP; write 0x52 W, 0xFB, 0x00, STOP → all bytes ACKed, ready=1, xfer_done pulses twice.
- Report read: stick_x=0x80, stick_y=0x7F, accel_x=0x2A5, accel_y=0x155, accel_z=0x3FF, z=1, c=0; write ptr 0x00, STOP; read 6 bytes, NACK last → 0x80,0x7F,0xA9,0x55,0xFF,0xD6; busy=0 after STOP.
- Wrong address 0x53 → no ACK (SDA stays high on 9th bit), busy=0, reg_ptr unchanged.
- Read before ready → every byte 0xFF; read 8 bytes after ready from ptr 0 → bytes 6,7 equal bytes 0,1 (wrap).
- Inputs change during read → returned bytes match snapshot taken at address ACK.
- Assert rst after 4 bits of a read byte → SDA released at once, ready=0; following full handshake+read succeeds.
